// File: rtl/llr_retry_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | llr_retry_ctrl_if : TX/RX/LLRB handshake bundle for llr_retry_ctrl       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface llr_retry_ctrl_if;
  logic        tx_flit_valid;
  logic        tx_ready;
  logic        rx_flit_good;
  logic        rx_crc_err;
  logic        rx_retry_req;
  logic        rx_retry_ack;
  logic        rx_ack_valid;
  logic [6:0]  rx_ack_count;
  logic        retry_stop_read;
  logic [7:0]  retry_wrt_ptr;
  logic        controller_wr_en;
  logic        controller_rd_en;
  logic        rd_ptr_eseq_set;
  logic        o_tx_stall;
  logic        o_tx_sel_replay;
  logic        o_send_retry_ack;
  logic        o_send_retry_req;
  logic [7:0]  o_retry_req_eseq;
  logic        o_link_fail;
  logic [15:0] o_replay_cnt;

  modport master (
    output tx_flit_valid, tx_ready, rx_flit_good, rx_crc_err, rx_retry_req,
           rx_retry_ack, rx_ack_valid, rx_ack_count, retry_stop_read, retry_wrt_ptr,
    input  controller_wr_en, controller_rd_en, rd_ptr_eseq_set, o_tx_stall,
           o_tx_sel_replay, o_send_retry_ack, o_send_retry_req, o_retry_req_eseq,
           o_link_fail, o_replay_cnt
  );

  modport slave (
    input  tx_flit_valid, tx_ready, rx_flit_good, rx_crc_err, rx_retry_req,
           rx_retry_ack, rx_ack_valid, rx_ack_count, retry_stop_read, retry_wrt_ptr,
    output controller_wr_en, controller_rd_en, rd_ptr_eseq_set, o_tx_stall,
           o_tx_sel_replay, o_send_retry_ack, o_send_retry_req, o_retry_req_eseq,
           o_link_fail, o_replay_cnt
  );
endinterface
`default_nettype wire

// File: rtl/llr_retry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | llr_retry_ctrl : CXL link-layer retry controller (LLRB strobes, replay,  |
// | Retry.Req/Ack sequencing). Optional LLR_REPLAY_STATS_EN replay counter.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module llr_retry_ctrl #(
  parameter int BUFFER_DEPTH = 64,
  parameter int ACK_TIMEOUT  = 255,
  parameter int MAX_RETRY    = 4
) (
  input logic             i_clk,
  input logic             i_rst_n,
  llr_retry_ctrl_if.slave bus
);
  localparam int c_tmr_w = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int c_rty_w = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [6:0]         c_full_lvl = 7'(BUFFER_DEPTH);
  localparam logic [c_tmr_w-1:0] c_tmr_max  = c_tmr_w'(ACK_TIMEOUT);
  localparam logic [c_rty_w-1:0] c_rty_max  = c_rty_w'(MAX_RETRY);

  typedef enum logic [1:0] {
    TX_NORMAL = 2'd0, TX_SEND_ACK = 2'd1, TX_REPLAY = 2'd2
  } tx_state_t;
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0, RX_SEND_REQ = 2'd1, RX_WAIT_ACK = 2'd2, RX_ABORT = 2'd3
  } rx_state_t;

  tx_state_t          r_tx_state, w_tx_next;
  rx_state_t          r_rx_state, w_rx_next;
  logic [c_tmr_w-1:0] r_timer, w_timer_next;
  logic [c_rty_w-1:0] r_retry_num, w_retry_next;
  logic [6:0]         r_occ, w_occ_next;
  logic [7:0]         r_rx_eseq;
  logic [5:0]         r_wr_cnt;
  logic [7:0]         w_occ_sum, w_ack_amt, w_occ_diff;
  logic               w_abort, w_full, w_send_req, w_wr_en, w_rd_en, w_eseq_set;
  logic               w_unused;

  assign w_abort    = (r_rx_state == RX_ABORT);
  assign w_full     = (r_occ == c_full_lvl);
  // A pending Retry.Ack outranks our own Retry.Req on the TX link.
  assign w_send_req = (r_rx_state == RX_SEND_REQ) && (r_tx_state != TX_SEND_ACK);

  always_comb begin
    w_tx_next  = r_tx_state;
    w_eseq_set = 1'b0;
    w_rd_en    = 1'b0;
    w_wr_en    = 1'b0;
    if (!w_abort) begin
      case (r_tx_state)
        TX_NORMAL: begin
          w_eseq_set = bus.rx_retry_req;
          w_wr_en    = bus.tx_flit_valid && bus.tx_ready && !w_full && !w_send_req;
          if (bus.rx_retry_req) w_tx_next = TX_SEND_ACK;
        end
        TX_SEND_ACK: if (bus.tx_ready) w_tx_next = TX_REPLAY;
        TX_REPLAY: begin
          w_rd_en = bus.tx_ready && !bus.retry_stop_read && !w_send_req;
          if (bus.retry_stop_read) w_tx_next = TX_NORMAL;
        end
        default: w_tx_next = TX_NORMAL;
      endcase
    end
  end

  always_comb begin
    w_rx_next    = r_rx_state;
    w_retry_next = r_retry_num;
    w_timer_next = '0;
    case (r_rx_state)
      RX_IDLE:     if (bus.rx_crc_err) w_rx_next = RX_SEND_REQ;
      RX_SEND_REQ: if (w_send_req && bus.tx_ready) w_rx_next = RX_WAIT_ACK;
      RX_WAIT_ACK: begin
        if (bus.rx_retry_ack) begin
          w_rx_next    = RX_IDLE;
          w_retry_next = '0;
        end else if (r_timer == c_tmr_max) begin
          w_retry_next = r_retry_num + 1'b1;
          w_rx_next    = (w_retry_next >= c_rty_max) ? RX_ABORT : RX_SEND_REQ;
        end else begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      default: w_rx_next = RX_ABORT;
    endcase
  end

  // Over-ack clamps the occupancy at zero instead of wrapping.
  assign w_ack_amt  = bus.rx_ack_valid ? {1'b0, bus.rx_ack_count} : 8'd0;
  assign w_occ_sum  = {1'b0, r_occ} + {7'd0, w_wr_en};
  assign w_occ_diff = w_occ_sum - w_ack_amt;
  assign w_occ_next = (w_ack_amt > w_occ_sum) ? 7'd0 : w_occ_diff[6:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_state  <= TX_NORMAL;
      r_rx_state  <= RX_IDLE;
      r_timer     <= '0;
      r_retry_num <= '0;
      r_occ       <= '0;
      r_rx_eseq   <= '0;
      r_wr_cnt    <= '0;
    end else begin
      r_tx_state  <= w_tx_next;
      r_rx_state  <= w_rx_next;
      r_timer     <= w_timer_next;
      r_retry_num <= w_retry_next;
      r_occ       <= w_occ_next;
      if (bus.rx_flit_good && r_rx_state == RX_IDLE) r_rx_eseq <= r_rx_eseq + 8'd1;
      if (w_wr_en) r_wr_cnt <= r_wr_cnt + 6'd1;
    end
  end

`ifdef LLR_REPLAY_STATS_EN
  logic [15:0] r_replay_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_replay_cnt <= '0;
    else if (r_tx_state == TX_SEND_ACK && w_tx_next == TX_REPLAY && r_replay_cnt != 16'hFFFF)
      r_replay_cnt <= r_replay_cnt + 16'd1;
  end
  assign bus.o_replay_cnt = r_replay_cnt;
`else
  assign bus.o_replay_cnt = 16'd0;
`endif

  assign bus.controller_wr_en = w_wr_en;
  assign bus.controller_rd_en = w_rd_en;
  assign bus.rd_ptr_eseq_set  = w_eseq_set;
  assign bus.o_tx_stall       = (r_tx_state != TX_NORMAL) || w_full || w_send_req || w_abort;
  assign bus.o_tx_sel_replay  = (r_tx_state == TX_REPLAY) && !w_abort;
  assign bus.o_send_retry_ack = (r_tx_state == TX_SEND_ACK) && !w_abort;
  assign bus.o_send_retry_req = w_send_req;
  assign bus.o_retry_req_eseq = r_rx_eseq;
  assign bus.o_link_fail      = w_abort;

  // The LLRB write pointer must track our own write strobes.
  a_wrt_ptr_tracks_writes: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    bus.retry_wrt_ptr[5:0] == r_wr_cnt);

  assign w_unused = ^{bus.retry_wrt_ptr, w_occ_diff[7]};
endmodule
`default_nettype wire

// File: tb/tb_llr_retry_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_llr_retry_ctrl : directed + random bench with occupancy reference     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_llr_retry_ctrl;
  localparam int DEPTH = 64;
  localparam int TMO   = 255;
  localparam int MAXR  = 4;
`ifdef LLR_REPLAY_STATS_EN
  localparam int EXP_REPLAYS = 2;
`else
  localparam int EXP_REPLAYS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  llr_retry_ctrl_if bus();
  llr_retry_ctrl #(.BUFFER_DEPTH(DEPTH), .ACK_TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave));

  int n_run = 0, n_fail = 0;
  int m_occ = 0, m_wr = 0, m_eseq = 0;
  int req_at[$];
  int fail_at;
  int gap;

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.tx_flit_valid = 0; bus.tx_ready = 0; bus.rx_flit_good = 0; bus.rx_crc_err = 0;
    bus.rx_retry_req = 0; bus.rx_retry_ack = 0; bus.rx_ack_valid = 0; bus.rx_ack_count = '0;
    bus.retry_stop_read = 1;
  endtask

  // Reference occupancy/write count: +1 per write, minus acked flits, floor 0.
  task automatic step(input bit wr);
    int a;
    a = bus.rx_ack_valid ? int'(bus.rx_ack_count) : 0;
    m_occ = m_occ + int'(wr) - a;
    if (m_occ < 0) m_occ = 0;
    m_wr = m_wr + int'(wr);
    @(posedge clk);
    #1;
    bus.retry_wrt_ptr = 8'(m_wr);
  endtask

  task automatic cyc(input string tag, input bit exp_wr);
    #1;
    chk1({tag, ".wr_en"}, bus.controller_wr_en, exp_wr);
    step(exp_wr);
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, ".wr_en"}, bus.controller_wr_en, 1'b0);
    chk1({tag, ".rd_en"}, bus.controller_rd_en, 1'b0);
    chk1({tag, ".eseq_set"}, bus.rd_ptr_eseq_set, 1'b0);
    chk1({tag, ".stall"}, bus.o_tx_stall, 1'b0);
    chk1({tag, ".sel_replay"}, bus.o_tx_sel_replay, 1'b0);
    chk1({tag, ".send_ack"}, bus.o_send_retry_ack, 1'b0);
    chk1({tag, ".send_req"}, bus.o_send_retry_req, 1'b0);
    chkn({tag, ".req_eseq"}, 32'(bus.o_retry_req_eseq), 32'd0);
    chk1({tag, ".link_fail"}, bus.o_link_fail, 1'b0);
    chkn({tag, ".replay_cnt"}, 32'(bus.o_replay_cnt), 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    m_occ = 0; m_wr = 0; m_eseq = 0;
    bus.retry_wrt_ptr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    bus.retry_wrt_ptr = '0;
    #12;
    chk_quiet("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // ---- Replay of 3 flits after 10 writes ----
    bus.tx_flit_valid = 1; bus.tx_ready = 1;
    for (int i = 0; i < 10; i++) cyc("a.write", 1'b1);
    bus.tx_flit_valid = 0;
    bus.rx_retry_req = 1;
    #1; chk1("a.eseq_set", bus.rd_ptr_eseq_set, 1'b1); chk1("a.stall0", bus.o_tx_stall, 1'b0);
    cyc("a.req", 1'b0);
    bus.rx_retry_req = 0;
    #1; chk1("a.eseq_set_1cyc", bus.rd_ptr_eseq_set, 1'b0); chk1("a.send_ack", bus.o_send_retry_ack, 1'b1);
    chk1("a.stall_ack", bus.o_tx_stall, 1'b1); chk1("a.rd_in_ack", bus.controller_rd_en, 1'b0);
    cyc("a.ack", 1'b0);
    bus.retry_stop_read = 0;
    for (int i = 0; i < 3; i++) begin
      #1; chk1("a.rd_en", bus.controller_rd_en, 1'b1); chk1("a.sel", bus.o_tx_sel_replay, 1'b1);
      chk1("a.ack_once", bus.o_send_retry_ack, 1'b0);
      cyc("a.replay", 1'b0);
    end
    bus.retry_stop_read = 1;
    #1; chk1("a.rd_stop", bus.controller_rd_en, 1'b0);
    cyc("a.stop", 1'b0);
    #1; chk1("a.stall_drop", bus.o_tx_stall, 1'b0); chk1("a.sel_drop", bus.o_tx_sel_replay, 1'b0);

    // ---- Fill to BUFFER_DEPTH, ack 4, same-cycle ack+write ----
    bus.tx_flit_valid = 1;
    for (int i = 0; i < 57; i++) begin
      #1; chk1("b.stall", bus.o_tx_stall, m_occ == DEPTH);
      cyc("b.fill", m_occ < DEPTH);
    end
    bus.tx_flit_valid = 0; bus.rx_ack_valid = 1; bus.rx_ack_count = 7'd4;
    cyc("b.ack4", 1'b0);
    bus.rx_ack_valid = 0; bus.tx_flit_valid = 1;
    for (int i = 0; i < 6; i++) cyc("b.refill", m_occ < DEPTH);
    bus.tx_flit_valid = 0; bus.rx_ack_valid = 1; bus.rx_ack_count = 7'd1;
    cyc("b.ack1", 1'b0);
    bus.tx_flit_valid = 1;
    cyc("b.ack_and_write", 1'b1);
    bus.rx_ack_valid = 0;
    cyc("b.last_slot", 1'b1);
    #1; chk1("b.full_stall", bus.o_tx_stall, 1'b1);
    cyc("b.blocked", 1'b0);

    // ---- Random traffic against the occupancy model, incl. over-ack ----
    bus.tx_flit_valid = 0; bus.rx_ack_valid = 1; bus.rx_ack_count = 7'd127;
    cyc("r.overack", 1'b0);
    for (int i = 0; i < 400; i++) begin
      bus.tx_flit_valid = ($urandom_range(0, 7) != 0);
      bus.tx_ready      = ($urandom_range(0, 7) != 0);
      bus.rx_flit_good  = ($urandom_range(0, 1) != 0);
      bus.rx_ack_valid  = (i < 200) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 7) == 0);
      bus.rx_ack_count  = 7'($urandom_range(0, (i < 200) ? 4 : 40));
      if (bus.rx_flit_good) m_eseq++;
      #1; chk1("r.stall", bus.o_tx_stall, m_occ == DEPTH);
      cyc("r.traffic", bus.tx_flit_valid && bus.tx_ready && (m_occ < DEPTH));
    end
    idle_inputs();
    #1; chkn("r.eseq", 32'(bus.o_retry_req_eseq), 32'(m_eseq % 256));

    // ---- Retry.Req with eseq=5, one timeout, Retry.Ack at wait cycle 20 ----
    do_reset();
    bus.rx_flit_good = 1;
    repeat (5) cyc("c.good", 1'b0);
    bus.rx_flit_good = 0; bus.rx_crc_err = 1;
    #1; chk1("c.req_not_yet", bus.o_send_retry_req, 1'b0);
    cyc("c.crc", 1'b0);
    bus.rx_crc_err = 0;
    #1; chk1("c.send_req", bus.o_send_retry_req, 1'b1); chkn("c.req_eseq", 32'(bus.o_retry_req_eseq), 32'd5);
    chk1("c.stall_req", bus.o_tx_stall, 1'b1);
    cyc("c.hold", 1'b0);
    bus.tx_ready = 1;
    cyc("c.grant", 1'b0);
    gap = 0;
    for (int n = 1; n <= 400; n++) begin
      #1;
      if (bus.o_send_retry_req) begin gap = n; break; end
      step(1'b0);
    end
    chkn("c.timeout_gap", 32'(gap), 32'(TMO + 2));
    cyc("c.regrant", 1'b0);
    bus.rx_flit_good = 1;
    repeat (19) cyc("c.wait", 1'b0);
    bus.rx_retry_ack = 1;
    cyc("c.ack", 1'b0);
    bus.rx_retry_ack = 0; bus.rx_flit_good = 0;
    #1; chk1("c.idle_req", bus.o_send_retry_req, 1'b0); chk1("c.idle_stall", bus.o_tx_stall, 1'b0);
    chkn("c.eseq_frozen", 32'(bus.o_retry_req_eseq), 32'd5);

    // ---- Abort: 4 Retry.Req then sticky link failure ----
    fail_at = -1;
    bus.rx_crc_err = 1; bus.tx_ready = 1;
    for (int c = 0; c < 1100; c++) begin
      #1;
      if (bus.o_send_retry_req) req_at.push_back(c);
      if (bus.o_link_fail && fail_at < 0) fail_at = c;
      step(1'b0);
      if (c == 0) bus.rx_crc_err = 0;
    end
    chkn("d.num_req", 32'(req_at.size()), 32'(MAXR));
    for (int i = 0; i < req_at.size() && i < MAXR; i++)
      chkn("d.req_time", 32'(req_at[i]), 32'(1 + i * (TMO + 2)));
    chkn("d.fail_time", 32'(fail_at), 32'(1 + MAXR * (TMO + 2)));
    bus.tx_flit_valid = 1; bus.rx_retry_req = 1; bus.rx_crc_err = 1; bus.rx_retry_ack = 1;
    repeat (5) begin
      #1; chk1("d.link_fail", bus.o_link_fail, 1'b1); chk1("d.stall", bus.o_tx_stall, 1'b1);
      chk1("d.eseq_set", bus.rd_ptr_eseq_set, 1'b0); chk1("d.send_ack", bus.o_send_retry_ack, 1'b0);
      chk1("d.send_req", bus.o_send_retry_req, 1'b0);
      cyc("d.sticky", 1'b0);
    end

    // ---- Priority: Retry.Req rx and CRC error in the same cycle ----
    do_reset();
    bus.tx_flit_valid = 1; bus.tx_ready = 1;
    repeat (3) cyc("e.write", 1'b1);
    bus.tx_flit_valid = 0; bus.rx_retry_req = 1; bus.rx_crc_err = 1;
    #1; chk1("e.eseq_set", bus.rd_ptr_eseq_set, 1'b1);
    cyc("e.both", 1'b0);
    bus.rx_retry_req = 0; bus.rx_crc_err = 0; bus.tx_ready = 0;
    repeat (5) begin
      #1; chk1("e.ack_wait", bus.o_send_retry_ack, 1'b1); chk1("e.req_masked", bus.o_send_retry_req, 1'b0);
      chk1("e.no_rd", bus.controller_rd_en, 1'b0); chk1("e.no_eseq_set", bus.rd_ptr_eseq_set, 1'b0);
      cyc("e.notready", 1'b0);
    end
    bus.tx_ready = 1; bus.retry_stop_read = 0;
    #1; chk1("e.ack_first", bus.o_send_retry_ack, 1'b1); chk1("e.req_after", bus.o_send_retry_req, 1'b0);
    cyc("e.ack_grant", 1'b0);
    #1; chk1("e.req_next", bus.o_send_retry_req, 1'b1); chk1("e.rd_blocked", bus.controller_rd_en, 1'b0);
    chk1("e.sel", bus.o_tx_sel_replay, 1'b1);
    cyc("e.req_grant", 1'b0);
    repeat (3) begin
      #1; chk1("e.rd_en", bus.controller_rd_en, 1'b1);
      cyc("e.replay", 1'b0);
    end
    bus.retry_stop_read = 1;
    cyc("e.stop", 1'b0);
    #1; chk1("e.stall_drop", bus.o_tx_stall, 1'b0);
    bus.rx_retry_ack = 1;
    cyc("e.rxack", 1'b0);
    bus.rx_retry_ack = 0;

    // Empty replay exits after one cycle.
    bus.rx_retry_req = 1;
    cyc("f.req", 1'b0);
    bus.rx_retry_req = 0;
    cyc("f.ack", 1'b0);
    #1; chk1("f.sel", bus.o_tx_sel_replay, 1'b1); chk1("f.rd", bus.controller_rd_en, 1'b0);
    cyc("f.empty", 1'b0);
    #1; chk1("f.exit", bus.o_tx_sel_replay, 1'b0); chk1("f.stall", bus.o_tx_stall, 1'b0);
    chkn("f.replay_cnt", 32'(bus.o_replay_cnt), 32'(EXP_REPLAYS));

    // ---- Asynchronous reset in the middle of a replay ----
    bus.rx_retry_req = 1;
    cyc("g.req", 1'b0);
    bus.rx_retry_req = 0;
    cyc("g.ack", 1'b0);
    bus.retry_stop_read = 0;
    #1; chk1("g.rd_live", bus.controller_rd_en, 1'b1);
    #2 rst_n = 0;
    m_occ = 0; m_wr = 0; bus.retry_wrt_ptr = '0;
    #1; chk_quiet("g.async");
    bus.retry_stop_read = 1;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk_quiet("g.after");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
